// File: rtl/core_sequencer_pkg.sv
// Shared definitions for the multi-cycle RV32I sequencer: state
// encodings, opcodes, pc/wb mux selects and decode helpers.
package core_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_HALT    = 3'd6
    } seq_state_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [1:0] PC_SEL_PLUS4  = 2'd0;
    localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
    localparam logic [1:0] PC_SEL_JALR   = 2'd2;

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD = 2'd1;
    localparam logic [1:0] WB_SEL_PC4  = 2'd2;

    // Bit positions inside the decoder's {j,u,b,s,i,r} flag vector.
    localparam int TYPE_R = 0;
    localparam int TYPE_I = 1;
    localparam int TYPE_S = 2;
    localparam int TYPE_B = 3;
    localparam int TYPE_U = 4;
    localparam int TYPE_J = 5;

    function automatic logic is_onehot6(input logic [5:0] v);
        return (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
    endfunction

    function automatic logic opc_legal(input logic [6:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/core_sequencer_seq_wait_counter.sv
// Loadable up/down wait counter shared by DECODE latency and bus timeout.
// Ports: clr/load/dec/inc controls, count value, zero and limit flags.
module seq_wait_counter #(
    parameter int W     = 4,
    parameter int LIMIT = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         zero,
    output logic         at_limit
);

    localparam logic [W-1:0] LIM_M1 = (LIMIT == 0) ? '0 : W'(LIMIT - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (dec) begin
            if (count_q != '0) count_d = count_q - W'(1);
        end else if (inc) begin
            // Saturate so a disabled timeout never wraps back to zero.
            if (count_q != '1) count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count    = count_q;
    assign zero     = (count_q == '0);
    // Flags the last allowed waiting cycle; a ready in that cycle still wins.
    assign at_limit = (LIMIT != 0) && (count_q == LIM_M1);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle RV32I control FSM: fetch, decode, execute, mem, writeback.
// Ports: imem/dmem handshakes, rf/pc strobes, mux selects, halt status.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int DECODE_LAT = 1,
    parameter int TIMEOUT    = 16,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    output logic             imem_req,
    input  logic             imem_ready,
    output logic             ir_load,
    input  logic [5:0]       instr_type,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    output logic             rf_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic [1:0]       wb_sel,
    output logic [2:0]       state,
    output logic             retire,
    output logic [CNT_W-1:0] retired_cnt,
    output logic             halted,
    output logic             illegal,
    output logic             bus_err
);

    // Wide enough for TIMEOUT-1 and for DECODE_LAT-1 (at most 6).
    localparam int CW = (TIMEOUT > 8) ? $clog2(TIMEOUT) : 3;
    localparam logic [CW-1:0] DEC_INIT = CW'(DECODE_LAT - 1);

    seq_state_e state_q, state_d;
    logic illegal_q, illegal_d;
    logic bus_err_q, bus_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Instruction class captured on the last DECODE cycle.
    logic ld_q, ld_d;
    logic st_q, st_d;
    logic jal_q, jal_d;
    logic jalr_q, jalr_d;
    logic br_q, br_d;
    logic wr_q, wr_d;

    logic          wc_clr, wc_load, wc_dec, wc_inc;
    logic [CW-1:0] wc_count;
    logic          wc_zero, wc_limit;

    seq_wait_counter #(
        .W     (CW),
        .LIMIT (TIMEOUT)
    ) u_wait (
        .clk      (clk),
        .reset    (reset),
        .clr      (wc_clr),
        .load     (wc_load),
        .load_val (DEC_INIT),
        .dec      (wc_dec),
        .inc      (wc_inc),
        .count    (wc_count),
        .zero     (wc_zero),
        .at_limit (wc_limit)
    );

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        cnt_d     = cnt_q;
        ld_d      = ld_q;
        st_d      = st_q;
        jal_d     = jal_q;
        jalr_d    = jalr_q;
        br_d      = br_q;
        wr_d      = wr_q;
        imem_req  = 1'b0;
        ir_load   = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        rf_we     = 1'b0;
        pc_we     = 1'b0;
        retire    = 1'b0;
        pc_sel    = PC_SEL_PLUS4;
        wb_sel    = WB_SEL_ALU;
        wc_clr    = 1'b0;
        wc_load   = 1'b0;
        wc_dec    = 1'b0;
        wc_inc    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                    wc_clr  = 1'b1;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                ir_load  = imem_ready;
                if (imem_ready) begin
                    state_d = S_DECODE;
                    wc_load = 1'b1;
                end else if (wc_limit) begin
                    state_d   = S_HALT;
                    bus_err_d = 1'b1;
                end else begin
                    wc_inc = 1'b1;
                end
            end
            S_DECODE: begin
                if (!wc_zero) begin
                    wc_dec = 1'b1;
                end else begin
                    ld_d   = (opcode == OPC_LOAD);
                    st_d   = (opcode == OPC_STORE);
                    jal_d  = (opcode == OPC_JAL);
                    jalr_d = (opcode == OPC_JALR);
                    br_d   = instr_type[TYPE_B];
                    wr_d   = instr_type[TYPE_R] | instr_type[TYPE_I]
                           | instr_type[TYPE_U] | instr_type[TYPE_J];
                    if (!is_onehot6(instr_type)) begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end else if (opcode == OPC_SYSTEM) begin
                        state_d = S_HALT;
                    end else if (!opc_legal(opcode)) begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end else begin
                        state_d = S_EXECUTE;
                    end
                end
            end
            S_EXECUTE: begin
                if (ld_q || st_q) begin
                    state_d = S_MEM;
                    wc_clr  = 1'b1;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = st_q;
                if (dmem_ready) begin
                    state_d = S_WB;
                end else if (wc_limit) begin
                    state_d   = S_HALT;
                    bus_err_d = 1'b1;
                end else begin
                    wc_inc = 1'b1;
                end
            end
            S_WB: begin
                pc_we  = 1'b1;
                retire = 1'b1;
                rf_we  = wr_q;
                cnt_d  = cnt_q + CNT_W'(1);
                if (jalr_q)
                    pc_sel = PC_SEL_JALR;
                else if (jal_q || (br_q && branch_taken))
                    pc_sel = PC_SEL_BRANCH;
                if (ld_q)
                    wb_sel = WB_SEL_LOAD;
                else if (jal_q || jalr_q)
                    wb_sel = WB_SEL_PC4;
                wc_clr  = 1'b1;
                state_d = run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            cnt_q     <= '0;
            ld_q      <= 1'b0;
            st_q      <= 1'b0;
            jal_q     <= 1'b0;
            jalr_q    <= 1'b0;
            br_q      <= 1'b0;
            wr_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            cnt_q     <= cnt_d;
            ld_q      <= ld_d;
            st_q      <= st_d;
            jal_q     <= jal_d;
            jalr_q    <= jalr_d;
            br_q      <= br_d;
            wr_q      <= wr_d;
        end
    end

    logic unused_count;
    assign unused_count = ^wc_count;

    assign state       = state_q;
    assign retired_cnt = cnt_q;
    assign halted      = (state_q == S_HALT);
    assign illegal     = illegal_q;
    assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed testbench for core_sequencer with hand-computed expectations.
// DUT uses default parameters: DECODE_LAT=1, TIMEOUT=16, CNT_W=32.
module tb_core_sequencer;

    localparam int CNT_W = 32;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_HALT   = 3'd6;

    localparam logic [5:0] T_R = 6'b000001;
    localparam logic [5:0] T_I = 6'b000010;
    localparam logic [5:0] T_S = 6'b000100;
    localparam logic [5:0] T_B = 6'b001000;
    localparam logic [5:0] T_J = 6'b100000;

    localparam logic [6:0] O_JAL    = 7'b1101111;
    localparam logic [6:0] O_JALR   = 7'b1100111;
    localparam logic [6:0] O_BRANCH = 7'b1100011;
    localparam logic [6:0] O_LOAD   = 7'b0000011;
    localparam logic [6:0] O_STORE  = 7'b0100011;
    localparam logic [6:0] O_OPIMM  = 7'b0010011;
    localparam logic [6:0] O_SYSTEM = 7'b1110011;

    logic             clk;
    logic             reset;
    logic             run;
    logic             imem_req;
    logic             imem_ready;
    logic             ir_load;
    logic [5:0]       instr_type;
    logic [6:0]       opcode;
    logic             branch_taken;
    logic             dmem_req;
    logic             dmem_we;
    logic             dmem_ready;
    logic             rf_we;
    logic             pc_we;
    logic [1:0]       pc_sel;
    logic [1:0]       wb_sel;
    logic [2:0]       state;
    logic             retire;
    logic [CNT_W-1:0] retired_cnt;
    logic             halted;
    logic             illegal;
    logic             bus_err;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    logic left;

    core_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .imem_req     (imem_req),
        .imem_ready   (imem_ready),
        .ir_load      (ir_load),
        .instr_type   (instr_type),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_ready   (dmem_ready),
        .rf_we        (rf_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .wb_sel       (wb_sel),
        .state        (state),
        .retire       (retire),
        .retired_cnt  (retired_cnt),
        .halted       (halted),
        .illegal      (illegal),
        .bus_err      (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s,
                              input int budget);
        for (int i = 0; i < budget && state !== s; i++) tick();
        check(tag, 32'(state), 32'(s));
    endtask

    // Leaves the DUT in FETCH with the fetch accepted on the next edge.
    task automatic start(input logic [5:0] t, input logic [6:0] op);
        instr_type = t;
        opcode     = op;
        imem_ready = 1'b1;
        run        = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        exp_cnt = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset        = 1'b0;
        run          = 1'b0;
        imem_ready   = 1'b0;
        instr_type   = T_I;
        opcode       = O_OPIMM;
        branch_taken = 1'b0;
        dmem_ready   = 1'b0;
        #12;
        check("rst_state", 32'(state), 32'(ST_IDLE));
        check("rst_cnt", retired_cnt, 0);
        check("rst_flags", {halted, illegal, bus_err}, 0);
        check("rst_strb", {imem_req, dmem_req, rf_we, pc_we, retire}, 0);
        reset = 1'b1;

        // ADDI, run dropped during EXECUTE
        imem_ready = 1'b1;
        run = 1'b1;
        tick();
        check("addi_fetch", {state, imem_req, ir_load}, {ST_FETCH, 2'b11});
        tick();
        check("addi_dec", 32'(state), 32'(ST_DECODE));
        tick();
        check("addi_exec", 32'(state), 32'(ST_EXEC));
        run = 1'b0;
        tick();
        check("addi_wb", 32'(state), 32'(ST_WB));
        check("addi_strb", {rf_we, pc_we, retire}, 3'b111);
        check("addi_sel", {wb_sel, pc_sel}, 4'b0000);
        exp_cnt++;
        tick();
        check("addi_idle", {state, retire}, {ST_IDLE, 1'b0});
        check("addi_cnt", retired_cnt, exp_cnt);

        // SW with dmem_ready on the 4th MEM cycle
        start(T_S, O_STORE);
        wait_state("sw_mem", ST_MEM, 6);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) dmem_ready = 1'b1;
            check("sw_req", {state, dmem_req, dmem_we}, {ST_MEM, 2'b11});
            tick();
        end
        dmem_ready = 1'b0;
        check("sw_wb", 32'(state), 32'(ST_WB));
        check("sw_strb", {rf_we, pc_we, dmem_req}, 3'b010);
        exp_cnt++;
        tick();
        check("sw_cnt", retired_cnt, exp_cnt);

        // BEQ taken
        branch_taken = 1'b1;
        start(T_B, O_BRANCH);
        wait_state("beq_t_wb", ST_WB, 6);
        check("beq_t", {pc_sel, rf_we}, {2'd1, 1'b0});
        exp_cnt++;
        tick();

        // BEQ not taken
        branch_taken = 1'b0;
        start(T_B, O_BRANCH);
        wait_state("beq_n_wb", ST_WB, 6);
        check("beq_n", {pc_sel, rf_we}, {2'd0, 1'b0});
        exp_cnt++;
        tick();

        // JALR
        start(T_I, O_JALR);
        wait_state("jalr_wb", ST_WB, 6);
        check("jalr", {pc_sel, wb_sel, rf_we}, {2'd2, 2'd2, 1'b1});
        exp_cnt++;
        tick();

        // JAL
        start(T_J, O_JAL);
        wait_state("jal_wb", ST_WB, 6);
        check("jal", {pc_sel, wb_sel, rf_we}, {2'd1, 2'd2, 1'b1});
        exp_cnt++;
        tick();

        // LOAD
        start(T_I, O_LOAD);
        wait_state("lw_mem", ST_MEM, 6);
        check("lw_req", {dmem_req, dmem_we}, 2'b10);
        dmem_ready = 1'b1;
        tick();
        dmem_ready = 1'b0;
        check("lw_wb", {state, wb_sel, rf_we}, {ST_WB, 2'd1, 1'b1});
        exp_cnt++;
        tick();
        check("lw_cnt", retired_cnt, exp_cnt);

        // Illegal: opcode 0, no type flags; HALT ignores run
        start(6'b000000, 7'b0000000);
        wait_state("ill0_halt", ST_HALT, 6);
        check("ill0_flags", {halted, illegal, bus_err}, 3'b110);
        run = 1'b1;
        left = 1'b0;
        repeat (20) begin
            tick();
            if (state !== ST_HALT || imem_req !== 1'b0) left = 1'b1;
        end
        check("halt_hold", left, 0);
        run = 1'b0;
        do_reset();
        check("ill0_rst", {state, illegal}, {ST_IDLE, 1'b0});

        // Illegal: two type flags set
        start(6'b000011, O_OPIMM);
        wait_state("ill1_halt", ST_HALT, 6);
        check("ill1_flags", {halted, illegal}, 2'b11);
        do_reset();

        // ECALL halts without the illegal cause
        start(T_I, O_SYSTEM);
        wait_state("ecall_halt", ST_HALT, 6);
        check("ecall_flags", {halted, illegal, bus_err}, 3'b100);
        do_reset();

        // Fetch timeout after 16 FETCH cycles
        instr_type = T_R;
        opcode     = 7'b0110011;
        imem_ready = 1'b0;
        run = 1'b1;
        tick();
        run = 1'b0;
        repeat (15) tick();
        check("to_c16", {state, imem_req}, {ST_FETCH, 1'b1});
        tick();
        check("to_halt", {state, bus_err, imem_req}, {ST_HALT, 2'b10});
        do_reset();

        // Ready on the 16th cycle wins over the limit
        run = 1'b1;
        tick();
        run = 1'b0;
        repeat (15) tick();
        imem_ready = 1'b1;
        #1;
        check("to_ready", ir_load, 1);
        tick();
        check("to_dec", {state, bus_err}, {ST_DECODE, 1'b0});
        wait_state("to_idle", ST_IDLE, 6);
        exp_cnt++;
        check("to_cnt", retired_cnt, exp_cnt);

        // Asynchronous reset while in MEM
        start(T_I, O_LOAD);
        wait_state("ar_mem", ST_MEM, 6);
        check("ar_req", dmem_req, 1);
        #1 reset = 1'b0;
        #1;
        check("ar_state", {state, dmem_req}, {ST_IDLE, 1'b0});
        check("ar_cnt", retired_cnt, 0);
        #1 reset = 1'b1;
        exp_cnt = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
